// File: rtl/best_move_select.sv
// Best-move selector: walks the move list, drives one evaluation per move and keeps the best signed score.
// Optional watchdog on the evaluator wait: define BEST_MOVE_WATCHDOG_EN.
module best_move_select #(
   parameter int MAX_POSITIONS_LOG2 = 8,
   parameter int EVAL_WIDTH         = 22
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                moves_ready,
   input  logic        [MAX_POSITIONS_LOG2-1:0] move_count,
   input  logic                                white_to_move,
   output logic        [MAX_POSITIONS_LOG2-1:0] move_index,
   output logic                                eval_start,
   input  logic signed [EVAL_WIDTH-1:0]         eval,
   input  logic                                eval_valid,
   output logic                                clear_eval,
   output logic                                clear_moves,
   output logic        [MAX_POSITIONS_LOG2-1:0] best_index,
   output logic signed [EVAL_WIDTH-1:0]         best_eval,
   output logic                                no_moves,
   output logic                                busy,
   output logic                                done,
   output logic                                timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_FLUSH = 3'd6;

   logic [2:0]                     state_q, state_d;
   logic [MAX_POSITIONS_LOG2-1:0]  move_index_q, move_index_d;
   logic [MAX_POSITIONS_LOG2-1:0]  count_q, count_d;
   logic                           white_q, white_d;
   logic [MAX_POSITIONS_LOG2-1:0]  best_index_q, best_index_d;
   logic signed [EVAL_WIDTH-1:0]   best_eval_q, best_eval_d;
   logic                           no_moves_q, no_moves_d;
   logic                           busy_q, busy_d;
   logic                           wd_abort;
   logic                           better;
   logic [MAX_POSITIONS_LOG2:0]    next_index;
`ifdef BEST_MOVE_WATCHDOG_EN
   logic [9:0]                     wdog_q, wdog_d;
   logic                           timeout_q, timeout_d;
`endif

   // Both operands are signed, so this is a full-width two's-complement compare.
   assign better     = white_q ? (eval > best_eval_q) : (eval < best_eval_q);
   assign next_index = {1'b0, move_index_q} + {{MAX_POSITIONS_LOG2{1'b0}}, 1'b1};

   always_comb begin
      // NOTE: every next-state signal takes its held value first, so no path through the case infers a latch.
      state_d      = state_q;
      move_index_d = move_index_q;
      count_d      = count_q;
      white_d      = white_q;
      best_index_d = best_index_q;
      best_eval_d  = best_eval_q;
      no_moves_d   = no_moves_q;
      busy_d       = busy_q;
      wd_abort     = 1'b0;
`ifdef BEST_MOVE_WATCHDOG_EN
      wdog_d       = wdog_q;
      timeout_d    = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (moves_ready) begin
               count_d      = move_count;
               white_d      = white_to_move;
               move_index_d = '0;
               busy_d       = 1'b1;
               best_index_d = '0;
               best_eval_d  = '0;
               no_moves_d   = (move_count == '0);
`ifdef BEST_MOVE_WATCHDOG_EN
               timeout_d    = 1'b0;
`endif
               state_d      = (move_count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ:  state_d = S_START;
         S_START: begin
`ifdef BEST_MOVE_WATCHDOG_EN
            wdog_d  = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (eval_valid) begin
               if (move_index_q == '0 || better) begin
                  best_index_d = move_index_q;
                  best_eval_d  = eval;
               end
               state_d = S_NEXT;
            end
`ifdef BEST_MOVE_WATCHDOG_EN
            else if (wdog_q == 10'h3FF) begin
               timeout_d = 1'b1;
               wd_abort  = 1'b1;
               state_d   = S_DONE;
            end else begin
               wdog_d = wdog_q + 10'd1;
            end
`endif
         end
         S_NEXT: begin
            if (next_index < {1'b0, count_q}) begin
               move_index_d = next_index[MAX_POSITIONS_LOG2-1:0];
               state_d      = S_READ;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: reset is asynchronous and every register is cleared, so an interrupted search leaves nothing behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         move_index_q <= '0;
         count_q      <= '0;
         white_q      <= 1'b0;
         best_index_q <= '0;
         best_eval_q  <= '0;
         no_moves_q   <= 1'b0;
         busy_q       <= 1'b0;
`ifdef BEST_MOVE_WATCHDOG_EN
         wdog_q       <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         move_index_q <= move_index_d;
         count_q      <= count_d;
         white_q      <= white_d;
         best_index_q <= best_index_d;
         best_eval_q  <= best_eval_d;
         no_moves_q   <= no_moves_d;
         busy_q       <= busy_d;
`ifdef BEST_MOVE_WATCHDOG_EN
         wdog_q       <= wdog_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   // Pulses decode straight from the state so they vanish the instant reset asserts.
   assign eval_start  = (state_q == S_START);
   assign clear_eval  = (state_q == S_NEXT) || wd_abort;
   assign clear_moves = (state_q == S_DONE);
   assign done        = (state_q == S_DONE);
   assign move_index  = move_index_q;
   assign best_index  = best_index_q;
   assign best_eval   = best_eval_q;
   assign no_moves    = no_moves_q;
   assign busy        = busy_q;
`ifdef BEST_MOVE_WATCHDOG_EN
   assign timeout     = timeout_q;
`else
   assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_best_move_select.sv
// Directed bench for best_move_select with a simple evaluator / move-generator model.
module tb_best_move_select;
   localparam int M = 8;
   localparam int E = 22;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 moves_ready;
   logic [M-1:0]         move_count;
   logic                 white_to_move;
   logic [M-1:0]         move_index;
   logic                 eval_start;
   logic signed [E-1:0]  eval;
   logic                 eval_valid;
   logic                 clear_eval;
   logic                 clear_moves;
   logic [M-1:0]         best_index;
   logic signed [E-1:0]  best_eval;
   logic                 no_moves;
   logic                 busy;
   logic                 done;
   logic                 timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int ev[8];
   int idx_log[$];
   int n_done, n_clr, n_start, n_busy, t_start, t_done;
   int cyc = 0;
   logic [44:0] all_out;

   best_move_select #(.MAX_POSITIONS_LOG2(M), .EVAL_WIDTH(E)) dut (
      .clk(clk), .reset(reset), .moves_ready(moves_ready), .move_count(move_count),
      .white_to_move(white_to_move), .move_index(move_index), .eval_start(eval_start),
      .eval(eval), .eval_valid(eval_valid), .clear_eval(clear_eval), .clear_moves(clear_moves),
      .best_index(best_index), .best_eval(best_eval), .no_moves(no_moves), .busy(busy),
      .done(done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   assign all_out = {move_index, eval_start, clear_eval, clear_moves, best_index, best_eval,
                     no_moves, busy, done, timeout};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Evaluator answers lat cycles after eval_start and holds eval_valid until clear_eval.
   // Moves from silent_from onward never get an answer; abort_move asserts reset in its first WAIT cycle.
   task automatic run_search(input logic white, input int count, input int lat,
                             input int silent_from, input int abort_move, input int budget);
      int  wait_ctr = -1;
      int  cur      = 0;
      int  post     = -1;
      bit  abort_now = 0;
      n_done = 0; n_clr = 0; n_start = 0; n_busy = 0; t_start = 0; t_done = 0;
      idx_log.delete();
      move_count    = count[M-1:0];
      white_to_move = white;
      moves_ready   = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1; cyc++;
         if (abort_now) begin
            reset = 1'b1;
            #1;
            break;
         end
         if (clear_eval) eval_valid = 1'b0;
         if (wait_ctr > 0) begin
            wait_ctr--;
            if (wait_ctr == 0) begin
               eval_valid = 1'b1;
               eval       = ev[cur][E-1:0];
            end
         end
         if (eval_start) begin
            n_start++;
            cur = int'(move_index);
            idx_log.push_back(cur);
            t_start  = cyc;
            wait_ctr = (cur >= silent_from) ? -1 : lat;
            if (cur == abort_move) abort_now = 1;
         end
         if (busy) n_busy++;
         if (clear_moves) n_clr++;
         if (done) begin
            n_done++;
            t_done      = cyc;
            moves_ready = 1'b0;
            post        = 2;
         end else if (post > 0) begin
            post--;
            if (post == 0) break;
         end
      end
   endtask

   task automatic reset_pulse();
      eval_valid  = 1'b0;
      moves_ready = 1'b0;
      reset       = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; moves_ready = 1'b0; move_count = '0; white_to_move = 1'b0;
      eval = '0; eval_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'(all_out), 64'd0);
      reset = 1'b0;

      // White, 10 -5 40
      ev = '{10, -5, 40, 0, 0, 0, 0, 0};
      run_search(1'b1, 3, 2, 99, -1, 200);
      check("w3_nidx", 64'(idx_log.size()), 64'd3);
      check("w3_idx0", 64'(idx_log[0]), 64'd0);
      check("w3_idx1", 64'(idx_log[1]), 64'd1);
      check("w3_idx2", 64'(idx_log[2]), 64'd2);
      check("w3_best_index", 64'(best_index), 64'd2);
      check("w3_best_eval", 64'(best_eval), 64'(40));
      check("w3_done_pulses", 64'(n_done), 64'd1);
      check("w3_clear_moves_pulses", 64'(n_clr), 64'd1);
      check("w3_no_moves", 64'(no_moves), 64'd0);
      check("w3_busy_after", 64'(busy), 64'd0);
      check("w3_timeout", 64'(timeout), 64'd0);

      // Black, 10 -5 -5: tie keeps index 1
      ev = '{10, -5, -5, 0, 0, 0, 0, 0};
      run_search(1'b0, 3, 3, 99, -1, 200);
      check("b3_best_index", 64'(best_index), 64'd1);
      check("b3_best_eval", 64'(best_eval), 64'(-5));
      check("b3_done_pulses", 64'(n_done), 64'd1);

      // Empty move list
      run_search(1'b1, 0, 2, 99, -1, 50);
      check("c0_no_moves", 64'(no_moves), 64'd1);
      check("c0_done_pulses", 64'(n_done), 64'd1);
      check("c0_clear_moves_pulses", 64'(n_clr), 64'd1);
      check("c0_eval_starts", 64'(n_start), 64'd0);
      check("c0_busy_cycles", 64'(n_busy), 64'd1);
      check("c0_best_index", 64'(best_index), 64'd0);

      // Single move at the most negative score
      ev = '{-2097152, 0, 0, 0, 0, 0, 0, 0};
      run_search(1'b1, 1, 1, 99, -1, 50);
      check("neg_best_eval", 64'(best_eval), 64'(-2097152));
      check("neg_best_index", 64'(best_index), 64'd0);
      check("neg_no_moves", 64'(no_moves), 64'd0);

      // Black, latency 1: 5 -3 8 -3 -> first -3 wins
      ev = '{5, -3, 8, -3, 0, 0, 0, 0};
      run_search(1'b0, 4, 1, 99, -1, 200);
      check("b4_best_index", 64'(best_index), 64'd1);
      check("b4_best_eval", 64'(best_eval), 64'(-3));
      check("b4_eval_starts", 64'(n_start), 64'd4);

      // White, all equal: index 0 stays
      ev = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_search(1'b1, 4, 2, 99, -1, 200);
      check("tie_best_index", 64'(best_index), 64'd0);

      // White, extreme positive beats -1
      ev = '{-1, 2097151, 0, 0, 0, 0, 0, 0};
      run_search(1'b1, 2, 2, 99, -1, 200);
      check("max_best_index", 64'(best_index), 64'd1);
      check("max_best_eval", 64'(best_eval), 64'(2097151));

      // Black, most negative beats most positive
      ev = '{2097151, -2097152, 0, 0, 0, 0, 0, 0};
      run_search(1'b0, 2, 2, 99, -1, 200);
      check("min_best_index", 64'(best_index), 64'd1);
      check("min_best_eval", 64'(best_eval), 64'(-2097152));

      // Reset in WAIT of move 1, then a clean rerun
      ev = '{100, 200, 300, 0, 0, 0, 0, 0};
      run_search(1'b1, 3, 2, 99, 1, 200);
      check("abort_outputs_zero", 64'(all_out), 64'd0);
      eval_valid  = 1'b0;
      moves_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      ev = '{3, 7, 0, 0, 0, 0, 0, 0};
      run_search(1'b1, 2, 2, 99, -1, 200);
      check("rerun_best_index", 64'(best_index), 64'd1);
      check("rerun_best_eval", 64'(best_eval), 64'(7));
      check("rerun_done_pulses", 64'(n_done), 64'd1);
      check("rerun_nidx", 64'(idx_log.size()), 64'd2);

      // Evaluator goes silent on move 1
      ev = '{9, 50, 0, 0, 0, 0, 0, 0};
`ifdef BEST_MOVE_WATCHDOG_EN
      run_search(1'b1, 2, 2, 1, -1, 1300);
      check("wd_done_pulses", 64'(n_done), 64'd1);
      check("wd_latency", 64'(t_done - t_start), 64'd1025);
      check("wd_timeout", 64'(timeout), 64'd1);
      check("wd_best_index", 64'(best_index), 64'd0);
      check("wd_best_eval", 64'(best_eval), 64'(9));
      check("wd_busy_after", 64'(busy), 64'd0);
`else
      run_search(1'b1, 2, 2, 1, -1, 1500);
      check("hang_done_pulses", 64'(n_done), 64'd0);
      check("hang_busy", 64'(busy), 64'd1);
      check("hang_eval_starts", 64'(n_start), 64'd2);
      check("hang_timeout", 64'(timeout), 64'd0);
`endif
      reset_pulse();
      check("final_reset_outputs", 64'(all_out), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
